// File: rtl/instr_fetch.sv
// Instruction fetch: walks a PC through program RAM and queues {instr, pc} for decode.
// Latency: RAM issue at N, capture at N+1, instr_valid at N+2 (start to first valid is 3 cycles).
// Backpressure: issues only while FIFO count + inflight < DEPTH; instr_ready low simply holds the head.

module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop_rdy,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Storage and pointers; flush empties the queue and drops any same-cycle push or pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop_rdy) rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(push_vld) - (PW+1)'(pop_rdy);
        end
    end

    assign head_dat = mem[rd_ptr];
endmodule

module instr_fetch #(
    parameter int           ADDR_W   = 11,
    parameter int           INSTR_W  = 64,
    parameter int           DEPTH    = 4,
    parameter logic [7:0]   STOP_OPC = 8'hFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_addr,
    input  logic                halt,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_addr,
    output logic                pram_ena,
    output logic                pram_rea,
    output logic [ADDR_W-1:0]   pram_addr,
    input  logic [INSTR_W-1:0]  pram_data,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [INSTR_W-1:0]  instr_data,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic                busy,
    output logic                done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]              state;
    logic [ADDR_W-1:0]       pc;
    logic [ADDR_W-1:0]       issued_pc;
    logic                    inflight;
    logic                    kill;
    logic                    done_r;
    logic [$clog2(DEPTH):0]  count;
    logic [INSTR_W+ADDR_W-1:0] head_dat;

    logic active;
    logic flush_req;
    logic fifo_flush;
    logic capture_vld;
    logic stop_hit;
    logic issue;
    logic push_vld;
    logic pop_rdy;

    assign active      = (state != IDLE);
    assign flush_req   = active && (halt || redirect_valid);
    // A fresh start also clears the queue so nothing from an earlier program survives.
    assign fifo_flush  = flush_req || (state == IDLE && start && !halt);
    assign capture_vld = inflight && !kill;
    assign stop_hit    = capture_vld && (pram_data[INSTR_W-1 -: 8] == STOP_OPC);
    // Credit rule: the read in flight already owns a FIFO slot, so the queue can never overflow.
    assign issue       = (state == RUN) && ((int'(count) + int'(inflight)) < DEPTH);
    assign push_vld    = capture_vld && !fifo_flush;
    assign pop_rdy     = instr_valid && instr_ready && !fifo_flush;

    // Control state, PC and the one-deep read tracking (inflight / kill).
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            issued_pc <= '0;
            inflight  <= 1'b0;
            kill      <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            inflight <= issue;
            // A read that leaves in the same cycle as a stop, redirect or halt must not land.
            kill     <= issue && (stop_hit || halt || redirect_valid);
            done_r   <= 1'b0;
            if (issue) begin
                issued_pc <= pc;
                pc        <= pc + ADDR_W'(1);
            end
            if (active && halt) begin
                state <= IDLE;
            end else if (active && redirect_valid) begin
                state <= RUN;
                pc    <= redirect_addr;
            end else begin
                case (state)
                    IDLE: if (start && !halt) begin
                        state <= RUN;
                        pc    <= start_addr;
                    end
                    RUN: if (stop_hit) state <= DRAIN;
                    DRAIN: if (count == '0 && !inflight) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    fifo #(
        .W     (INSTR_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (fifo_flush),
        .push_vld (push_vld),
        .push_dat ({pram_data, issued_pc}),
        .pop_rdy  (pop_rdy),
        .head_dat (head_dat),
        .count    (count)
    );

    assign pram_ena    = issue;
    assign pram_rea    = issue;
    assign pram_addr   = issue ? pc : '0;
    assign instr_valid = (count != '0);
    assign instr_data  = head_dat[INSTR_W+ADDR_W-1:ADDR_W];
    assign instr_pc    = head_dat[ADDR_W-1:0];
    assign busy        = active;
    assign done        = done_r;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a one-cycle registered program RAM model.
// Inputs are driven and outputs sampled on the falling edge of clk.
// Expected words come from exp_word(), the same table that fills the RAM model.

module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] start_addr;
    logic        halt;
    logic        redirect_valid;
    logic [10:0] redirect_addr;
    logic        pram_ena;
    logic        pram_rea;
    logic [10:0] pram_addr;
    logic [63:0] pram_data = '0;
    logic        instr_valid;
    logic        instr_ready;
    logic [63:0] instr_data;
    logic [10:0] instr_pc;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int issue_cnt = 0;
    logic saw7 = 1'b0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .start_addr     (start_addr),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .pram_ena       (pram_ena),
        .pram_rea       (pram_rea),
        .pram_addr      (pram_addr),
        .pram_data      (pram_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .busy           (busy),
        .done           (done)
    );

    function automatic logic [63:0] exp_word(input logic [10:0] a);
        if (a == 11'h005 || a == 11'h012 || a == 11'h021 || a == 11'h031)
            return {8'hFF, 45'd0, a};
        return {8'h00, 16'hA5A5, 29'd0, a};
    endfunction

    always @(posedge clk) begin
        if (pram_ena && pram_rea) pram_data <= exp_word(pram_addr);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (pram_ena) issue_cnt++;
        if (pram_ena && pram_addr == 11'd7) saw7 = 1'b1;
    endtask

    // Expects n consecutive deliveries starting at pc first, one per cycle.
    task automatic expect_seq(input logic [10:0] first, input int n);
        logic [10:0] a;
        for (int k = 0; k < n; k++) begin
            a = first + 11'(k);
            chk("seq_vld", 64'(instr_valid), 64'd1);
            chk("seq_pc",  64'(instr_pc), 64'(a));
            chk("seq_dat", instr_data, exp_word(a));
            step();
        end
    endtask

    task automatic wait_done(input int limit);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            if (done) seen = 1'b1;
            else step();
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("done_busy", 64'(busy), 64'd0);
        step();
        chk("done_once", 64'(done), 64'd0);
    endtask

    task automatic kick(input logic [10:0] addr);
        start_addr = addr;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; start_addr = '0; halt = 1'b0;
        redirect_valid = 1'b0; redirect_addr = '0; instr_ready = 1'b0;
        step(); step();
        chk("rst_ena",   64'(pram_ena), 64'd0);
        chk("rst_addr",  64'(pram_addr), 64'd0);
        chk("rst_vld",   64'(instr_valid), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        reset = 1'b0;
        step();

        // Basic program 0..5 with STOP at 5.
        instr_ready = 1'b1;
        saw7 = 1'b0;
        kick(11'h000);
        chk("s1_busy", 64'(busy), 64'd1);
        chk("s1_ena",  64'(pram_ena), 64'd1);
        chk("s1_rea",  64'(pram_rea), 64'd1);
        chk("s1_addr", 64'(pram_addr), 64'd0);
        chk("s1_vld",  64'(instr_valid), 64'd0);
        step();
        chk("s2_vld",  64'(instr_valid), 64'd0);
        step();
        expect_seq(11'h000, 6);
        chk("s9_vld",  64'(instr_valid), 64'd0);
        chk("s9_busy", 64'(busy), 64'd1);
        chk("s9_done", 64'(done), 64'd0);
        step();
        chk("s10_busy", 64'(busy), 64'd0);
        chk("s10_done", 64'(done), 64'd1);
        step();
        chk("s11_done", 64'(done), 64'd0);
        chk("no_addr7", 64'(saw7), 64'd0);

        // Backpressure: decoder stalls for 10 cycles.
        instr_ready = 1'b0;
        issue_cnt = 0;
        kick(11'h000);
        repeat (9) step();
        chk("bp_issues", 64'(issue_cnt), 64'd4);
        chk("bp_ena",    64'(pram_ena), 64'd0);
        chk("bp_vld",    64'(instr_valid), 64'd1);
        chk("bp_pc",     64'(instr_pc), 64'd0);
        instr_ready = 1'b1;
        expect_seq(11'h000, 6);
        wait_done(10);

        // Redirect while PC 2 is at the head.
        kick(11'h000);
        step(); step();
        expect_seq(11'h000, 2);
        chk("rd_head", 64'(instr_pc), 64'd2);
        redirect_valid = 1'b1;
        redirect_addr = 11'h010;
        step();
        redirect_valid = 1'b0;
        chk("rd1_vld",  64'(instr_valid), 64'd0);
        chk("rd1_ena",  64'(pram_ena), 64'd1);
        chk("rd1_addr", 64'(pram_addr), 64'h10);
        step();
        chk("rd2_vld",  64'(instr_valid), 64'd0);
        step();
        expect_seq(11'h010, 3);
        wait_done(10);

        // Halt together with redirect; halt wins.
        instr_ready = 1'b0;
        kick(11'h000);
        step(); step();
        halt = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr = 11'h010;
        step();
        halt = 1'b0;
        redirect_valid = 1'b0;
        chk("h_busy", 64'(busy), 64'd0);
        chk("h_vld",  64'(instr_valid), 64'd0);
        chk("h_done", 64'(done), 64'd0);
        instr_ready = 1'b1;
        kick(11'h020);
        chk("h_rst_busy", 64'(busy), 64'd1);
        chk("h_rst_addr", 64'(pram_addr), 64'h20);
        step(); step();
        expect_seq(11'h020, 2);
        wait_done(10);

        // PC wrap at the top of the address space.
        kick(11'h7FE);
        step(); step();
        expect_seq(11'h7FE, 3);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk("w_busy", 64'(busy), 64'd0);
        chk("w_done", 64'(done), 64'd0);

        // Reset with a full FIFO, then a clean restart.
        instr_ready = 1'b0;
        kick(11'h000);
        repeat (8) step();
        chk("r_full", 64'(instr_valid), 64'd1);
        reset = 1'b1;
        step();
        chk("r_ena",  64'(pram_ena), 64'd0);
        chk("r_rea",  64'(pram_rea), 64'd0);
        chk("r_addr", 64'(pram_addr), 64'd0);
        chk("r_vld",  64'(instr_valid), 64'd0);
        chk("r_dat",  instr_data, 64'd0);
        chk("r_pc",   64'(instr_pc), 64'd0);
        chk("r_busy", 64'(busy), 64'd0);
        chk("r_done", 64'(done), 64'd0);
        reset = 1'b0;
        instr_ready = 1'b1;
        kick(11'h030);
        chk("r1_vld", 64'(instr_valid), 64'd0);
        step();
        chk("r2_vld", 64'(instr_valid), 64'd0);
        step();
        expect_seq(11'h030, 2);
        wait_done(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
